// File: rtl/serial_borrowselect_subtractor_pkg.sv
// rtl/serial_borrowselect_subtractor_pkg.sv - shared types and constants for the serial borrow-select subtractor
package serial_borrowselect_subtractor_pkg;

    // Control states of the slice sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_SLICE  = 4;
    localparam int DEF_SLICES = DEF_WIDTH / DEF_SLICE;

    // Slice index width; a single-slice build still needs one index bit
    function automatic int idx_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_SLICES);

endpackage

// File: rtl/serial_borrowselect_subtractor_if.sv
// rtl/serial_borrowselect_subtractor_if.sv - operand/result handshake bundle (ovf present when SUB_OVF_EN is defined)
interface serial_borrowselect_subtractor_if
    import serial_borrowselect_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;

    // Operand producer / result consumer side
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    // Operand producer / result consumer side
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif

endinterface

// File: rtl/serial_borrowselect_subtractor_sub_slice_select.sv
// rtl/serial_borrowselect_subtractor_sub_slice_select.sv - one SLICE-bit borrow-select subtract stage
module sub_slice_select #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             borrow_i,
    output logic [SLICE-1:0] diff_o,
    output logic             borrow_o
);

    // One extra MSB per variant: it ends up set exactly when the slice borrows out
    logic [SLICE:0] res_b0;
    logic [SLICE:0] res_b1;

    assign res_b0 = {1'b0, a_i} - {1'b0, b_i};
    assign res_b1 = {1'b0, a_i} - {1'b0, b_i} - (SLICE+1)'(1);

    // Late-arriving registered borrow only drives the final mux
    always_comb begin
        if (borrow_i) begin
            diff_o   = res_b1[SLICE-1:0];
            borrow_o = res_b1[SLICE];
        end else begin
            diff_o   = res_b0[SLICE-1:0];
            borrow_o = res_b0[SLICE];
        end
    end

endmodule

// File: rtl/serial_borrowselect_subtractor.sv
// rtl/serial_borrowselect_subtractor.sv - multi-cycle A-B-Bin, one slice per clock (ovf output with SUB_OVF_EN)
module serial_borrowselect_subtractor
    import serial_borrowselect_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    serial_borrowselect_subtractor_if.slave bus
);

    localparam int SLICES = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             bout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] slice_diff;
    logic             slice_borrow;

    // Pick the operand slice addressed by the current index
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_slice = a_q[i*SLICE +: SLICE];
                b_slice = b_q[i*SLICE +: SLICE];
            end
        end
    end

    sub_slice_select #(
        .SLICE(SLICE)
    ) u_slice (
        .a_i     (a_slice),
        .b_i     (b_slice),
        .borrow_i(borrow_q),
        .diff_o  (slice_diff),
        .borrow_o(slice_borrow)
    );

    // Merge the fresh slice into the result, leaving the other slices untouched
    always_comb begin
        diff_d = diff_q;
        for (int i = 0; i < SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                diff_d[i*SLICE +: SLICE] = slice_diff;
            end
        end
    end

    assign idx_d = idx_q + IDX_W'(1);

`ifdef SUB_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Final slice carries the result MSB, so overflow is known on the last BUSY cycle
    assign ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_diff[SLICE-1] != a_q[WIDTH-1]);

    // Overflow flag captured alongside bout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_BUSY && idx_q == LAST_IDX) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // Sequencer: accept operands, walk the slices LSB first, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        borrow_q   <= bus.bin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    diff_q   <= diff_d;
                    borrow_q <= slice_borrow;
                    idx_q    <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        bout_q      <= slice_borrow;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_borrowselect_subtractor.sv
// tb/tb_serial_borrowselect_subtractor.sv - scoreboard bench for serial_borrowselect_subtractor (covers ovf when SUB_OVF_EN is defined)
module tb_serial_borrowselect_subtractor;
    import serial_borrowselect_subtractor_pkg::*;

    localparam int WIDTH  = 8;
    localparam int SLICE  = 4;
    localparam int SLICES = WIDTH / SLICE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_borrowselect_subtractor_if #(.WIDTH(WIDTH)) bus();

    serial_borrowselect_subtractor #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t m;
        int ai, bi, r, sa, sbv, s;
        ai  = int'(a);
        bi  = int'(b);
        r   = ai - bi - int'(bin);
        m.d = WIDTH'(r + (1 << WIDTH));
        m.bo = (ai < bi + int'(bin));
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        s   = sa - sbv - int'(bin);
        m.ov = (s < -(1 << (WIDTH-1))) || (s > (1 << (WIDTH-1)) - 1);
        return m;
    endfunction

    // Monitor: compare each result the cycle it is handed over
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("diff", 32'(bus.diff), 32'(mon_e.d));
                chk("bout", 32'(bus.bout), 32'(mon_e.bo));
`ifdef SUB_OVF_EN
                chk("ovf", 32'(bus.ovf), 32'(mon_e.ov));
`endif
            end
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         input int hold, input bit junk, input bit early);
        exp_t e;
        int   t0;
        int   k;
        e = model(a, b, bin);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            k++;
            if (k > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        t0 = cyc;
        bus.in_valid = 1'b0;
        if (early) bus.out_ready = 1'b1;
        if (junk && !early) begin
            bus.in_valid = 1'b1;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.bin      = 1'($urandom);
        end
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            k++;
            if (k > 50) begin
                chk("done_timeout", 32'd0, 32'd1);
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b0;
                return;
            end
        end
        chk("latency", 32'(cyc - t0), 32'(SLICES));
        if (!early) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
                chk("hold_diff", 32'(bus.diff), 32'(e.d));
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_diff"}, 32'(bus.diff), 32'd0);
        chk({tag, "_bout"}, 32'(bus.bout), 32'd0);
`ifdef SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    // Accept an op, let it run cycles edges, then pull reset low between edges
    task automatic abort_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int cycles, input string tag);
        @(negedge clk);
        chk({tag, "_pre_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_held_out_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h35, 8'h12, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h10, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 1, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'hA7, 8'h3C, 1'b1, 5, 1'b1, 1'b0);
        do_op(8'h44, 8'h45, 1'b0, 0, 1'b0, 1'b1);

        abort_op(8'h5A, 8'h33, 0, "rst_busy");
        do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        abort_op(8'h9C, 8'h21, SLICES + 1, "rst_done");
        do_op(8'hFF, 8'hFF, 1'b0, 2, 1'b1, 1'b0);

`ifdef SUB_OVF_EN
        do_op(8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
